// File: rtl/la_capture_pkg.sv
// Shared types and helpers for the logic-analyzer capture sequencer.
package la_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_ARMED,
        ST_FLUSH,
        ST_ARB_FLUSH,
        ST_READ,
        ST_WAIT
    } cap_state_t;

    localparam int DEFAULT_PTR_WIDTH = 29;

    // A single pod still needs a 1-bit select so the port never collapses to zero width.
    function automatic int pod_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/la_capture_sequencer_flush.sv
// Per-pod sticky flush-complete collection with a bounded wait.
module la_flush_collector
    import la_capture_pkg::*;
#(
    parameter int NUM_PODS      = 2,
    parameter int FLUSH_TIMEOUT = 65535
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                active,
    input  logic [NUM_PODS-1:0] pod_flush_complete,
    output logic                all_done,
    output logic                timed_out
);

    localparam int TW = $clog2(FLUSH_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(FLUSH_TIMEOUT - 1);

    logic [NUM_PODS-1:0] sticky_reg;
    logic [TW-1:0]       tmo_cnt_reg;

    // Sticky bits and counter are held clear whenever the FLUSH phase is not active,
    // so every entry starts from zero and stray completes are ignored.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PODS; gi++) begin : g_sticky
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sticky_reg[gi] <= 1'b0;
                end else if (!active) begin
                    sticky_reg[gi] <= 1'b0;
                end else if (pod_flush_complete[gi]) begin
                    sticky_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_reg <= '0;
        end else if (!active) begin
            tmo_cnt_reg <= '0;
        end else if (!timed_out) begin
            tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
        end
    end

    // A complete arriving this cycle counts immediately.
    assign all_done  = active && (&(sticky_reg | pod_flush_complete));
    assign timed_out = active && (tmo_cnt_reg == TMO_LAST);

endmodule

// File: rtl/la_capture_sequencer.sv
// Capture sequencer: trigger reset, capture, pod/arbiter flush, then streams
// every pod's write pointers out over a valid/ready handshake.
module la_capture_sequencer
    import la_capture_pkg::*;
#(
    parameter int NUM_PODS      = 2,
    parameter int PTRS_PER_POD  = 8,
    parameter int PTR_WIDTH     = DEFAULT_PTR_WIDTH,
    parameter int RST_CYCLES    = 16,
    parameter int FLUSH_TIMEOUT = 65535
) (
    input  logic                              clk_ram_2x,
    input  logic                              rst,
    input  logic                              arm,
    input  logic                              stop,
    output logic                              trig_rst,
    output logic                              capture_en,
    output logic                              capture_flush,
    input  logic [NUM_PODS-1:0]               pod_flush_complete,
    output logic                              flush_arbiter,
    input  logic                              flush_done,
    output logic                              ptr_rd_en,
    output logic [pod_width(NUM_PODS)-1:0]    ptr_rd_pod,
    output logic [$clog2(PTRS_PER_POD)-1:0]   ptr_rd_addr,
    input  logic [NUM_PODS*PTR_WIDTH-1:0]     ptr_rd_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [pod_width(NUM_PODS)-1:0]    out_pod,
    output logic [$clog2(PTRS_PER_POD)-1:0]   out_index,
    output logic [PTR_WIDTH-1:0]              out_ptr,
    output logic                              out_last,
    output logic                              busy,
    output logic                              timeout_err
);

    localparam int PW = pod_width(NUM_PODS);
    localparam int AW = $clog2(PTRS_PER_POD);
    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam logic [PW-1:0] LAST_POD = PW'(NUM_PODS - 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(PTRS_PER_POD - 1);
    localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

    cap_state_t state_reg, state_next;

    logic [RW-1:0]        rst_cnt_reg;
    logic [PW-1:0]        pod_cnt_reg;
    logic [AW-1:0]        idx_cnt_reg;
    logic                 trig_rst_reg, capture_en_reg, capture_flush_reg;
    logic                 flush_arbiter_reg, ptr_rd_en_reg, busy_reg, timeout_err_reg;
    logic                 out_valid_reg, out_last_reg;
    logic [PW-1:0]        out_pod_reg;
    logic [AW-1:0]        out_index_reg;
    logic [PTR_WIDTH-1:0] out_ptr_reg;
    logic                 capture_word, transfer;
    logic                 all_done, timed_out;
    logic [PTR_WIDTH-1:0] pod_ptr [NUM_PODS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PODS; gi++) begin : g_pod_ptr
            assign pod_ptr[gi] = ptr_rd_data[gi*PTR_WIDTH +: PTR_WIDTH];
        end
    endgenerate

    la_flush_collector #(
        .NUM_PODS      (NUM_PODS),
        .FLUSH_TIMEOUT (FLUSH_TIMEOUT)
    ) u_flush (
        .clk                (clk_ram_2x),
        .rst                (rst),
        .active             (state_reg == ST_FLUSH),
        .pod_flush_complete (pod_flush_complete),
        .all_done           (all_done),
        .timed_out          (timed_out)
    );

    always_ff @(posedge clk_ram_2x or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // WAIT covers two phases: the capture cycle (out_valid still low) and the handshake.
    always_comb begin
        state_next   = state_reg;
        capture_word = 1'b0;
        transfer     = 1'b0;
        case (state_reg)
            ST_IDLE:      if (arm) state_next = ST_RESET;
            ST_RESET:     if (rst_cnt_reg == RST_LAST) state_next = ST_ARMED;
            ST_ARMED:     if (stop) state_next = ST_FLUSH;
            ST_FLUSH:     if (all_done || timed_out) state_next = ST_ARB_FLUSH;
            ST_ARB_FLUSH: if (flush_done) state_next = ST_READ;
            ST_READ:      state_next = ST_WAIT;
            ST_WAIT: begin
                if (!out_valid_reg) begin
                    capture_word = 1'b1;
                end else if (out_ready) begin
                    transfer   = 1'b1;
                    state_next = out_last_reg ? ST_IDLE : ST_READ;
                end
            end
            default:      state_next = ST_IDLE;
        endcase
    end

    // Phase outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk_ram_2x or posedge rst) begin
        if (rst) begin
            rst_cnt_reg       <= '0;
            trig_rst_reg      <= 1'b0;
            capture_en_reg    <= 1'b0;
            capture_flush_reg <= 1'b0;
            flush_arbiter_reg <= 1'b0;
            ptr_rd_en_reg     <= 1'b0;
            busy_reg          <= 1'b0;
            timeout_err_reg   <= 1'b0;
        end else begin
            rst_cnt_reg       <= (state_reg == ST_RESET) ? rst_cnt_reg + RW'(1) : '0;
            trig_rst_reg      <= (state_next == ST_RESET);
            capture_en_reg    <= (state_next == ST_ARMED);
            capture_flush_reg <= (state_next == ST_FLUSH);
            flush_arbiter_reg <= (state_next == ST_ARB_FLUSH);
            ptr_rd_en_reg     <= (state_next == ST_READ);
            busy_reg          <= (state_next != ST_IDLE);
            if (state_reg == ST_IDLE && arm) begin
                timeout_err_reg <= 1'b0;
            end else if (state_reg == ST_FLUSH && timed_out && !all_done) begin
                timeout_err_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_ram_2x or posedge rst) begin
        if (rst) begin
            pod_cnt_reg   <= '0;
            idx_cnt_reg   <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_pod_reg   <= '0;
            out_index_reg <= '0;
            out_ptr_reg   <= '0;
        end else begin
            if (state_reg == ST_IDLE) begin
                pod_cnt_reg <= '0;
                idx_cnt_reg <= '0;
            end else if (transfer) begin
                if (idx_cnt_reg == LAST_IDX) begin
                    idx_cnt_reg <= '0;
                    pod_cnt_reg <= pod_cnt_reg + PW'(1);
                end else begin
                    idx_cnt_reg <= idx_cnt_reg + AW'(1);
                end
            end
            // Fields are only written on capture, so they hold through a stall.
            if (capture_word) begin
                out_valid_reg <= 1'b1;
                out_pod_reg   <= pod_cnt_reg;
                out_index_reg <= idx_cnt_reg;
                out_ptr_reg   <= pod_ptr[pod_cnt_reg];
                out_last_reg  <= (pod_cnt_reg == LAST_POD) && (idx_cnt_reg == LAST_IDX);
            end else if (transfer) begin
                out_valid_reg <= 1'b0;
                out_last_reg  <= 1'b0;
            end
        end
    end

    assign trig_rst      = trig_rst_reg;
    assign capture_en    = capture_en_reg;
    assign capture_flush = capture_flush_reg;
    assign flush_arbiter = flush_arbiter_reg;
    assign ptr_rd_en     = ptr_rd_en_reg;
    assign ptr_rd_pod    = pod_cnt_reg;
    assign ptr_rd_addr   = idx_cnt_reg;
    assign out_valid     = out_valid_reg;
    assign out_pod       = out_pod_reg;
    assign out_index     = out_index_reg;
    assign out_ptr       = out_ptr_reg;
    assign out_last      = out_last_reg;
    assign busy          = busy_reg;
    assign timeout_err   = timeout_err_reg;

endmodule
